// File: rtl/rf_host_cmd_master.sv
// rf_host_cmd_master
// MCU-side initiator for the transceiver configuration protocol (mode 3,
// M1=M0=1). A single-word request is accepted in IDLE. The block then:
//   1. drives the transceiver into mode 3, lets the pins settle and waits
//      for AUX;
//   2. sends the command frame through a byte UART;
//   3. collects and checks the reply (or, for the reset command, waits for
//      an AUX low-then-high pulse);
//   4. restores the caller's mode and reports done/error.
//
// Ports
//   internal_clk        rising-edge clock for all logic
//   rst                 synchronous active-high reset
//   cmd_valid/ready     request handshake; ready only in IDLE
//   cmd_op[2:0]         0 save cfg, 1 temp cfg, 2 read cfg, 3 read version,
//                       4 reset, 5-7 illegal
//   cmd_cfg[39:0]       ADDH,ADDL,SPED,CHAN,OPTION (ADDH in MSB byte)
//   op_mode[1:0]        {M1,M0} used while idle and restored after commands
//   M0, M1              transceiver mode pins
//   AUX                 transceiver ready (1 = idle), asynchronous input
//   tx_data/tx_use      byte and one-cycle send strobe toward UART TX
//   tx_flag             UART TX can accept a byte
//   rx_data/rx_flag     received byte and one-cycle strobe from UART RX
//   rsp_data[47:0]      reply bytes, first byte in MSB of the used width
//   done                one-cycle completion pulse
//   error/err_code      result; 0 AUX timeout, 1 reply timeout,
//                       2 reply mismatch, 3 illegal op
module rf_host_cmd_master #(
  parameter int DATA_WIDTH       = 8,
  parameter int MODE_SETTLE_CLK  = 2000,
  parameter int AUX_TIMEOUT_CLK  = 1000000,
  parameter int RESP_TIMEOUT_CLK = 500000,
  parameter int TX_GAP_CLK       = 2,
  parameter logic [DATA_WIDTH-1:0] HEAD_SAVE   = 8'hC0,
  parameter logic [DATA_WIDTH-1:0] HEAD_TEMP   = 8'hC2,
  parameter logic [DATA_WIDTH-1:0] RET_CONFIG  = 8'hC1,
  parameter logic [DATA_WIDTH-1:0] RET_VERSION = 8'hC3,
  parameter logic [DATA_WIDTH-1:0] RESET_CMD   = 8'hC4
) (
  input  logic                    internal_clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [5*DATA_WIDTH-1:0] cmd_cfg,
  input  logic [1:0]              op_mode,
  output logic                    M0,
  output logic                    M1,
  input  logic                    AUX,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_use,
  input  logic                    tx_flag,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_flag,
  output logic [6*DATA_WIDTH-1:0] rsp_data,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code
);

  localparam int DW = DATA_WIDTH;

  // One shared counter covers settle, AUX and reply timeouts, so it is
  // sized to the largest of them and saturates instead of wrapping.
  localparam int CNT_MAX_A = (MODE_SETTLE_CLK > AUX_TIMEOUT_CLK) ? MODE_SETTLE_CLK : AUX_TIMEOUT_CLK;
  localparam int CNT_MAX   = (CNT_MAX_A > RESP_TIMEOUT_CLK) ? CNT_MAX_A : RESP_TIMEOUT_CLK;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int GAP_W     = (TX_GAP_CLK > 0) ? $clog2(TX_GAP_CLK + 1) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(MODE_SETTLE_CLK - 1);
  localparam logic [CNT_W-1:0] AUX_LAST    = CNT_W'(AUX_TIMEOUT_CLK - 1);
  localparam logic [CNT_W-1:0] RESP_LAST   = CNT_W'(RESP_TIMEOUT_CLK - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;
  localparam logic [GAP_W-1:0] GAP_LOAD    = GAP_W'(TX_GAP_CLK);
  localparam logic [3*DW-1:0]  PAD3        = '0;

  localparam logic [3:0] ST_IDLE        = 4'd0;
  localparam logic [3:0] ST_MODE_SET    = 4'd1;
  localparam logic [3:0] ST_WAIT_AUX    = 4'd2;
  localparam logic [3:0] ST_SEND        = 4'd3;
  localparam logic [3:0] ST_RECV        = 4'd4;
  localparam logic [3:0] ST_CHECK       = 4'd5;
  localparam logic [3:0] ST_WAIT_RST    = 4'd6;
  localparam logic [3:0] ST_RESTORE     = 4'd7;
  localparam logic [3:0] ST_RESTORE_AUX = 4'd8;
  localparam logic [3:0] ST_DONE        = 4'd9;

  logic [3:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_inc;
  logic [GAP_W-1:0] gap_reg;
  logic [2:0]       op_reg;
  logic [6*DW-1:0]  frame_reg;
  logic [2:0]       tx_len_reg;
  logic [2:0]       rx_len_reg;
  logic [2:0]       idx_reg;
  logic [2:0]       rx_cnt_reg;
  logic             aux_meta_reg;
  logic             aux_sync_reg;
  logic             seen_low_reg;
  logic [1:0]       m_reg;
  logic [DW-1:0]    tx_data_reg;
  logic             tx_use_reg;
  logic [6*DW-1:0]  rsp_reg;
  logic             done_reg;
  logic             error_reg;
  logic [1:0]       err_code_reg;
  logic             ready_en_reg;

  logic [6*DW-1:0]  frame_next;
  logic [2:0]       tx_len_next;
  logic [2:0]       rx_len_next;
  logic             op_illegal;
  logic             accept;
  logic             tx_last;
  logic             rx_last;
  logic             check_ok;
  logic [DW-1:0]    frame_byte [8];

  assign cmd_ready = (state_reg == ST_IDLE) && ready_en_reg;
  assign accept    = cmd_valid && cmd_ready;
  assign M0        = m_reg[0];
  assign M1        = m_reg[1];
  assign tx_data   = tx_data_reg;
  assign tx_use    = tx_use_reg;
  assign rsp_data  = rsp_reg;
  assign done      = done_reg;
  assign error     = error_reg;
  assign err_code  = err_code_reg;

  assign op_illegal = (cmd_op > 3'd4);
  assign cnt_inc    = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;
  assign tx_last    = (idx_reg == tx_len_reg - 3'd1);
  assign rx_last    = (rx_cnt_reg == rx_len_reg - 3'd1);

  // Frame byte i sits at the i-th byte from the MSB of frame_reg; slots 6
  // and 7 only exist so a 3-bit index always addresses a defined entry.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_frame_byte
      assign frame_byte[gi] = frame_reg[(6-gi)*DW-1 -: DW];
    end
    for (gi = 6; gi < 8; gi++) begin : g_frame_pad
      assign frame_byte[gi] = '0;
    end
  endgenerate

  // Frame and reply length for the request presented on the inputs.
  always_comb begin
    frame_next  = '0;
    tx_len_next = 3'd3;
    rx_len_next = 3'd6;
    case (cmd_op)
      3'd0: begin
        frame_next  = {HEAD_SAVE, cmd_cfg};
        tx_len_next = 3'd6;
      end
      3'd1: begin
        frame_next  = {HEAD_TEMP, cmd_cfg};
        tx_len_next = 3'd6;
      end
      3'd2: frame_next = {RET_CONFIG, RET_CONFIG, RET_CONFIG, PAD3};
      3'd3: begin
        frame_next  = {RET_VERSION, RET_VERSION, RET_VERSION, PAD3};
        rx_len_next = 3'd4;
      end
      3'd4: begin
        frame_next  = {RESET_CMD, RESET_CMD, RESET_CMD, PAD3};
        rx_len_next = 3'd0;
      end
      default: begin
        frame_next  = '0;
      end
    endcase
  end

  // Reply check. The version reply is only 4 bytes long and is right
  // aligned in rsp_reg, so its first byte sits at [31:24].
  always_comb begin
    check_ok = 1'b1;
    case (op_reg)
      3'd0, 3'd1: check_ok = (rsp_reg == frame_reg);
      3'd2:       check_ok = (rsp_reg[6*DW-1 -: DW] == HEAD_SAVE);
      3'd3:       check_ok = (rsp_reg[4*DW-1 -: DW] == RET_VERSION);
      default:    check_ok = 1'b1;
    endcase
  end

  always_ff @(posedge internal_clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      gap_reg      <= '0;
      op_reg       <= '0;
      frame_reg    <= '0;
      tx_len_reg   <= '0;
      rx_len_reg   <= '0;
      idx_reg      <= '0;
      rx_cnt_reg   <= '0;
      aux_meta_reg <= 1'b0;
      aux_sync_reg <= 1'b0;
      seen_low_reg <= 1'b0;
      m_reg        <= 2'b00;
      tx_data_reg  <= '0;
      tx_use_reg   <= 1'b0;
      rsp_reg      <= '0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      err_code_reg <= 2'd0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      aux_meta_reg <= AUX;
      aux_sync_reg <= aux_meta_reg;
      tx_use_reg   <= 1'b0;
      done_reg     <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          m_reg <= op_mode;
          if (accept) begin
            op_reg       <= cmd_op;
            frame_reg    <= frame_next;
            tx_len_reg   <= tx_len_next;
            rx_len_reg   <= rx_len_next;
            idx_reg      <= '0;
            rx_cnt_reg   <= '0;
            cnt_reg      <= '0;
            gap_reg      <= '0;
            seen_low_reg <= 1'b0;
            rsp_reg      <= '0;
            error_reg    <= 1'b0;
            err_code_reg <= 2'd0;
            if (op_illegal) begin
              // Rejected without touching the pins.
              done_reg     <= 1'b1;
              error_reg    <= 1'b1;
              err_code_reg <= 2'd3;
            end else begin
              // Pins switch on the accept edge so the full settle window
              // is spent in mode 3.
              m_reg     <= 2'b11;
              state_reg <= ST_MODE_SET;
            end
          end
        end

        ST_MODE_SET: begin
          m_reg <= 2'b11;
          if (cnt_reg == SETTLE_LAST) begin
            cnt_reg   <= '0;
            state_reg <= ST_WAIT_AUX;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        ST_WAIT_AUX: begin
          if (aux_sync_reg) begin
            cnt_reg   <= '0;
            state_reg <= ST_SEND;
          end else if (cnt_reg == AUX_LAST) begin
            error_reg    <= 1'b1;
            err_code_reg <= 2'd0;
            cnt_reg      <= '0;
            m_reg        <= op_mode;
            state_reg    <= ST_RESTORE;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        ST_SEND: begin
          // After each byte tx_flag is ignored for TX_GAP_CLK cycles,
          // giving a minimum pulse spacing of TX_GAP_CLK+1.
          if (gap_reg != '0) begin
            gap_reg <= gap_reg - 1'b1;
          end else if (tx_flag) begin
            tx_use_reg  <= 1'b1;
            tx_data_reg <= frame_byte[idx_reg];
            idx_reg     <= idx_reg + 3'd1;
            gap_reg     <= GAP_LOAD;
            if (tx_last) begin
              cnt_reg      <= '0;
              seen_low_reg <= 1'b0;
              state_reg    <= (op_reg == 3'd4) ? ST_WAIT_RST : ST_RECV;
            end
          end
        end

        ST_RECV: begin
          if (rx_flag) begin
            rsp_reg    <= {rsp_reg[5*DW-1:0], rx_data};
            rx_cnt_reg <= rx_cnt_reg + 3'd1;
          end
          // The final byte takes priority over a timeout in the same cycle.
          if (rx_flag && rx_last) begin
            state_reg <= ST_CHECK;
          end else if (cnt_reg == RESP_LAST) begin
            error_reg    <= 1'b1;
            err_code_reg <= 2'd1;
            cnt_reg      <= '0;
            m_reg        <= op_mode;
            state_reg    <= ST_RESTORE;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        ST_CHECK: begin
          if (!check_ok) begin
            error_reg    <= 1'b1;
            err_code_reg <= 2'd2;
          end
          cnt_reg   <= '0;
          m_reg     <= op_mode;
          state_reg <= ST_RESTORE;
        end

        ST_WAIT_RST: begin
          // The module reboots: AUX must drop and come back.
          if (!seen_low_reg && !aux_sync_reg) begin
            seen_low_reg <= 1'b1;
          end
          if (seen_low_reg && aux_sync_reg) begin
            cnt_reg   <= '0;
            m_reg     <= op_mode;
            state_reg <= ST_RESTORE;
          end else if (cnt_reg == AUX_LAST) begin
            error_reg    <= 1'b1;
            err_code_reg <= 2'd0;
            cnt_reg      <= '0;
            m_reg        <= op_mode;
            state_reg    <= ST_RESTORE;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        ST_RESTORE: begin
          m_reg <= op_mode;
          if (cnt_reg == SETTLE_LAST) begin
            cnt_reg   <= '0;
            state_reg <= ST_RESTORE_AUX;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        ST_RESTORE_AUX: begin
          m_reg <= op_mode;
          if (aux_sync_reg) begin
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else if (cnt_reg == AUX_LAST) begin
            // An earlier error is the root cause; keep it.
            if (!error_reg) begin
              error_reg    <= 1'b1;
              err_code_reg <= 2'd0;
            end
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        ST_DONE: begin
          m_reg     <= op_mode;
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_host_cmd_master.sv
// Self-checking bench for rf_host_cmd_master. A small transceiver model
// drives AUX, accepts UART TX bytes and answers with reply bytes; the
// expected outcome of every command is derived from the protocol rules.
module tb_rf_host_cmd_master;

  localparam int S   = 20;
  localparam int AT  = 300;
  localparam int RT  = 200;
  localparam int GAP = 2;

  logic        internal_clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [39:0] cmd_cfg;
  logic [1:0]  op_mode;
  logic        M0, M1;
  logic        AUX;
  logic [7:0]  tx_data;
  logic        tx_use;
  logic        tx_flag;
  logic [7:0]  rx_data;
  logic        rx_flag;
  logic [47:0] rsp_data;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  rf_host_cmd_master #(
    .DATA_WIDTH(8), .MODE_SETTLE_CLK(S), .AUX_TIMEOUT_CLK(AT),
    .RESP_TIMEOUT_CLK(RT), .TX_GAP_CLK(GAP)
  ) dut (
    .internal_clk(internal_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cfg(cmd_cfg), .op_mode(op_mode),
    .M0(M0), .M1(M1), .AUX(AUX),
    .tx_data(tx_data), .tx_use(tx_use), .tx_flag(tx_flag),
    .rx_data(rx_data), .rx_flag(rx_flag),
    .rsp_data(rsp_data), .done(done), .error(error), .err_code(err_code)
  );

  always #5 internal_clk = ~internal_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transceiver model configuration: 0 AUX high, 1 AUX stuck low,
  // 2 reboot pulse after the reset frame, 3 no reboot pulse.
  int  aux_mode;
  bit  tx_flag_random;

  logic [7:0] reply_q[$];
  logic [7:0] reply_copy[$];
  logic [7:0] tx_seen[$];
  logic [7:0] exp_frame[$];

  bit          got_done;
  int          lat;
  int          tx_min_gap;
  logic [1:0]  m_at_tx;
  logic [1:0]  m_done;
  logic        err_r;
  logic [1:0]  code_r;
  logic [47:0] rsp_r;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bytes the protocol puts on the wire for a command.
  task automatic model_frame(input logic [2:0] op, input logic [39:0] cfg);
    exp_frame.delete();
    case (op)
      3'd0, 3'd1: begin
        exp_frame.push_back(op == 3'd0 ? 8'hC0 : 8'hC2);
        for (int i = 0; i < 5; i++) exp_frame.push_back(cfg[39-8*i -: 8]);
      end
      3'd2: repeat (3) exp_frame.push_back(8'hC1);
      3'd3: repeat (3) exp_frame.push_back(8'hC3);
      3'd4: repeat (3) exp_frame.push_back(8'hC4);
      default: ;
    endcase
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge internal_clk);
    check_eq("ready_wait", 64'(cmd_ready), 64'd1);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [39:0] cfg, input logic [1:0] mode);
    int last_tx;
    int rx_wait;
    int aux_t;
    int exp_tx;
    model_frame(op, cfg);
    exp_tx = (aux_mode == 1) ? 0 : exp_frame.size();
    tx_seen.delete();
    got_done   = 0;
    tx_min_gap = 1000;
    m_at_tx    = 2'b00;
    last_tx    = -1000;
    aux_t      = 0;
    lat        = 0;
    op_mode    = mode;
    AUX        = (aux_mode == 1) ? 1'b0 : 1'b1;
    if (!tx_flag_random) tx_flag = 1'b1;
    repeat (3) @(negedge internal_clk);
    wait_ready();
    cmd_op    = op;
    cmd_cfg   = cfg;
    cmd_valid = 1'b1;
    rx_wait   = int'($urandom_range(0, 3));
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge internal_clk);
      cmd_valid = 1'b0;
      rx_flag   = 1'b0;
      if (tx_use) begin
        if (tx_seen.size() == 0) m_at_tx = {M1, M0};
        if (cyc - last_tx < tx_min_gap) tx_min_gap = cyc - last_tx;
        last_tx = cyc;
        tx_seen.push_back(tx_data);
      end
      if (done) begin
        got_done = 1;
        lat      = cyc;
        err_r    = error;
        code_r   = err_code;
        rsp_r    = rsp_data;
        m_done   = {M1, M0};
        break;
      end
      if (tx_flag_random) tx_flag = ($urandom_range(0, 3) != 0);
      if (exp_tx > 0 && tx_seen.size() == exp_tx && reply_q.size() > 0) begin
        if (rx_wait == 0) begin
          rx_flag = 1'b1;
          rx_data = reply_q.pop_front();
          rx_wait = int'($urandom_range(0, 3));
        end else begin
          rx_wait--;
        end
      end
      if (aux_mode == 2 && tx_seen.size() == 3) begin
        aux_t++;
        if (aux_t == 10)  AUX = 1'b0;
        if (aux_t == 110) AUX = 1'b1;
      end
    end
    rx_flag = 1'b0;
    check_eq("done_seen", 64'(got_done), 64'd1);
  endtask

  // Expected result of the last command, from the protocol rules.
  task automatic verify(input string name, input logic [2:0] op, input logic [39:0] cfg, input logic [1:0] mode);
    logic [47:0] exp_rsp;
    logic [47:0] got_pk;
    logic [47:0] exp_pk;
    logic        exp_err;
    logic [1:0]  exp_code;
    int          exp_len;
    int          n;
    bit          ok;
    model_frame(op, cfg);
    exp_rsp  = '0;
    exp_err  = 1'b0;
    exp_code = 2'd0;
    if (op > 3'd4) begin
      exp_err  = 1'b1;
      exp_code = 2'd3;
      exp_frame.delete();
    end else if (aux_mode == 1) begin
      exp_err = 1'b1;
      exp_frame.delete();
    end else if (op == 3'd4) begin
      exp_err = (aux_mode != 2);
    end else begin
      exp_len = (op == 3'd3) ? 4 : 6;
      n = (reply_copy.size() < exp_len) ? reply_copy.size() : exp_len;
      for (int i = 0; i < n; i++) exp_rsp = {exp_rsp[39:0], reply_copy[i]};
      if (n < exp_len) begin
        exp_err  = 1'b1;
        exp_code = 2'd1;
      end else begin
        ok = 1;
        if (op <= 3'd1) begin
          for (int i = 0; i < 6; i++) if (reply_copy[i] != exp_frame[i]) ok = 0;
        end else if (op == 3'd2) begin
          ok = (reply_copy[0] == 8'hC0);
        end else begin
          ok = (reply_copy[0] == 8'hC3);
        end
        if (!ok) begin
          exp_err  = 1'b1;
          exp_code = 2'd2;
        end
      end
    end
    got_pk = '0;
    exp_pk = '0;
    foreach (tx_seen[i])   got_pk = {got_pk[39:0], tx_seen[i]};
    foreach (exp_frame[i]) exp_pk = {exp_pk[39:0], exp_frame[i]};
    check_eq({name, "_error"},    64'(err_r),  64'(exp_err));
    check_eq({name, "_err_code"}, 64'(code_r), 64'(exp_code));
    check_eq({name, "_rsp"},      64'(rsp_r),  64'(exp_rsp));
    check_eq({name, "_tx_count"}, 64'(tx_seen.size()), 64'(exp_frame.size()));
    check_eq({name, "_tx_bytes"}, 64'(got_pk), 64'(exp_pk));
    check_eq({name, "_mode_done"}, 64'(m_done), 64'(mode));
    if (tx_seen.size() > 0) begin
      check_eq({name, "_mode3_tx"}, 64'(m_at_tx), 64'd3);
      if (tx_seen.size() > 1)
        check_eq({name, "_tx_gap"}, 64'(tx_min_gap >= GAP + 1), 64'd1);
    end
    $display("cmd %s op=%0d mode=%0d tx=%0d lat=%0d error=%0b code=%0d rsp=%012h",
             name, op, mode, tx_seen.size(), lat, err_r, code_r, rsp_r);
  endtask

  task automatic run_and_verify(input string name, input logic [2:0] op, input logic [39:0] cfg, input logic [1:0] mode);
    reply_copy = reply_q;
    run_cmd(op, cfg, mode);
    verify(name, op, cfg, mode);
    reply_q.delete();
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [39:0] r_cfg;
    logic [1:0]  r_mode;
    int          n_tx;
    int          k;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_cfg = '0; op_mode = 2'b01;
    AUX = 1'b1; tx_flag = 1'b1; rx_data = '0; rx_flag = 1'b0;
    tx_flag_random = 0; aux_mode = 0;
    repeat (3) @(negedge internal_clk);
    check_eq("rst_m",        64'({M1, M0}), 64'd0);
    check_eq("rst_tx_use",   64'(tx_use),   64'd0);
    check_eq("rst_tx_data",  64'(tx_data),  64'd0);
    check_eq("rst_rsp",      64'(rsp_data), 64'd0);
    check_eq("rst_done",     64'(done),     64'd0);
    check_eq("rst_error",    64'(error),    64'd0);
    check_eq("rst_err_code", 64'(err_code), 64'd0);
    check_eq("rst_ready",    64'(cmd_ready), 64'd0);
    rst = 1'b0;
    @(negedge internal_clk);
    check_eq("rst_ready_after", 64'(cmd_ready), 64'd1);

    // Read version.
    reply_q = '{8'hC3, 8'h32, 8'h27, 8'h02};
    run_and_verify("version", 3'd3, 40'h0, 2'b00);
    check_eq("version_rsp_const", 64'(rsp_r), 64'h0000_C332_2702);

    // Save config, correct echo then a corrupted byte 3.
    reply_q = '{8'hC0, 8'h00, 8'h00, 8'h1A, 8'h17, 8'h44};
    run_and_verify("save_ok", 3'd0, 40'h00_00_1A_17_44, 2'b00);
    check_eq("save_rsp_const", 64'(rsp_r), 64'h0000_C000_001A_1744);
    reply_q = '{8'hC0, 8'h00, 8'h00, 8'h1B, 8'h17, 8'h44};
    run_and_verify("save_bad", 3'd0, 40'h00_00_1A_17_44, 2'b00);

    // AUX never rises.
    aux_mode = 1;
    run_and_verify("aux_low", 3'd1, 40'h12_34_56_78_9A, 2'b01);
    check_eq("aux_low_latency", 64'(lat >= S + AT && lat <= 2 * S + 2 * AT + 10), 64'd1);
    aux_mode = 0;

    // Short reply, then an illegal op.
    reply_q = '{8'hC0, 8'h00, 8'h00};
    run_and_verify("short", 3'd2, 40'h0, 2'b10);
    run_and_verify("illegal", 3'd6, 40'h0, 2'b10);
    check_eq("illegal_latency", 64'(lat), 64'd1);

    // Reset command with and without the reboot pulse.
    aux_mode = 2;
    run_and_verify("reset_ok", 3'd4, 40'h0, 2'b00);
    aux_mode = 3;
    run_and_verify("reset_nopulse", 3'd4, 40'h0, 2'b00);
    aux_mode = 0;

    // Reset in the middle of SEND.
    tx_flag = 1'b1; AUX = 1'b1; op_mode = 2'b10;
    repeat (3) @(negedge internal_clk);
    wait_ready();
    cmd_op = 3'd0; cmd_cfg = 40'h11_22_33_44_55; cmd_valid = 1'b1;
    n_tx = 0;
    for (int c = 0; c < 500 && n_tx < 2; c++) begin
      @(negedge internal_clk);
      cmd_valid = 1'b0;
      if (tx_use) n_tx++;
    end
    check_eq("midrst_two_bytes", 64'(n_tx), 64'd2);
    rst = 1'b1;
    @(negedge internal_clk);
    check_eq("midrst_tx_use", 64'(tx_use), 64'd0);
    check_eq("midrst_m", 64'({M1, M0}), 64'd0);
    check_eq("midrst_ready_low", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    @(negedge internal_clk);
    check_eq("midrst_ready", 64'(cmd_ready), 64'd1);
    reply_q = '{8'hC2, 8'hAB, 8'hCD, 8'h1C, 8'h17, 8'h44};
    run_and_verify("after_rst", 3'd1, 40'hAB_CD_1C_17_44, 2'b01);

    // Randomized commands.
    for (int it = 0; it < 24; it++) begin
      tx_flag_random = (it % 2 == 1);
      r_op   = 3'($urandom_range(0, 7));
      if (r_op > 3'd4 && $urandom_range(0, 1) == 0) r_op = 3'($urandom_range(0, 3));
      r_cfg  = {8'($urandom), 32'($urandom)};
      r_mode = 2'($urandom_range(0, 3));
      aux_mode = 0;
      reply_q.delete();
      if (r_op == 3'd4) aux_mode = ($urandom_range(0, 2) == 0) ? 3 : 2;
      if (r_op <= 3'd1) begin
        model_frame(r_op, r_cfg);
        reply_q = exp_frame;
        if ($urandom_range(0, 2) == 0) begin
          k = int'($urandom_range(0, 5));
          reply_q[k] = reply_q[k] ^ 8'(1 << $urandom_range(0, 7));
        end
      end else if (r_op == 3'd2) begin
        reply_q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hC0);
        repeat (5) reply_q.push_back(8'($urandom));
      end else if (r_op == 3'd3) begin
        reply_q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hC3);
        repeat (3) reply_q.push_back(8'($urandom));
      end
      if (reply_q.size() > 0) begin
        if ($urandom_range(0, 5) == 0) begin
          k = int'($urandom_range(1, 3));
          repeat (k) void'(reply_q.pop_back());
        end else begin
          k = int'($urandom_range(0, 2));
          repeat (k) reply_q.push_back(8'($urandom));
        end
      end
      run_and_verify($sformatf("rand%0d", it), r_op, r_cfg, r_mode);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
